bram_port_arbiter: RTL and testbench

//   Shares one BRAM port between NUM_REQ requesters (e.g. AXI-Lite config path and TLB lookup).

---
 rtl/bram_port_arbiter.sv | 104 ++++++++++
 tb/tb_bram_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port with per-requester lock
// and latency-matched read-response routing back to the issuing requester.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic [NUM_REQ-1:0]              Req_SI,
  input  logic [NUM_REQ-1:0]              Lock_SI,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   Addr_DI,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   Wr_DI,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] WrEn_SI,
  output logic [NUM_REQ-1:0]              Gnt_SO,
  output logic [NUM_REQ-1:0]              RValid_SO,
  output logic [DATA_WIDTH-1:0]           RData_DO,
  output logic                            Bram_Clk_CO,
  output logic                            Bram_Rst_RO,
  output logic                            Bram_En_SO,
  output logic [ADDR_WIDTH-1:0]           Bram_Addr_SO,
  output logic [DATA_WIDTH-1:0]           Bram_Wr_DO,
  output logic [DATA_WIDTH/8-1:0]         Bram_WrEn_SO,
  input  logic [DATA_WIDTH-1:0]           Bram_Rd_DI
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  ptr_q, ptr_d, own_q, own_d, rr_sel, sel;
  logic                           any, gnt_vld, acc, rd;
  logic [BW-1:0]                  wen;
  logic [RD_LATENCY-1:0]          vld_q, vld_d;
  logic [RD_LATENCY-1:0][IW-1:0]  idx_q, idx_d;

  // Scan downward so the closest requester at or after the pointer wins.
  always_comb begin
    rr_sel = '0;
    any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (Req_SI[(int'(ptr_q) + k) % NUM_REQ]) begin
        rr_sel = IW'((int'(ptr_q) + k) % NUM_REQ);
        any    = 1'b1;
      end
    end
  end

  assign sel          = (state_q == LOCKED) ? own_q : rr_sel;
  assign gnt_vld      = Rst_RBI & ((state_q == LOCKED) | any);
  assign Gnt_SO       = gnt_vld ? NUM_REQ'(1) << sel : '0;
  assign acc          = gnt_vld & Req_SI[sel];
  assign wen          = WrEn_SI[int'(sel)*BW +: BW];
  assign rd           = acc & ~|wen;
  assign Bram_Clk_CO  = Clk_CI;
  assign Bram_Rst_RO  = ~Rst_RBI;
  assign Bram_En_SO   = acc;
  assign Bram_Addr_SO = Addr_DI[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign Bram_Wr_DO   = Wr_DI[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign Bram_WrEn_SO = acc ? wen : '0;
  assign RValid_SO    = vld_q[RD_LATENCY-1] ? NUM_REQ'(1) << idx_q[RD_LATENCY-1] : '0;
  assign RData_DO     = vld_q[RD_LATENCY-1] ? Bram_Rd_DI : '0;

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    ptr_d    = ptr_q;
    vld_d    = '0;
    idx_d    = '0;
    vld_d[0] = rd;
    idx_d[0] = sel;
    for (int k = 1; k < RD_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      idx_d[k] = idx_q[k-1];
    end
    if (state_q == LOCKED) begin
      if (!Lock_SI[own_q]) state_d = IDLE;
    end else if (acc) begin
      ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      if (Lock_SI[sel]) begin
        state_d = LOCKED;
        own_d   = sel;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed literal checks plus randomized traffic compared
// every cycle against a queue-based behavioural model of the arbiter.
module tb_bram_port_arbiter;
  localparam int N = 3, DW = 32, AW = 16, LAT = 2, BW = DW / 8;

  typedef struct {int due; int idx;} rsp_t;

  logic                    clk = 1'b0, rst_n;
  logic [N-1:0]            req = '0, lock = '0;
  logic [N-1:0][AW-1:0]    addr = '0;
  logic [N-1:0][DW-1:0]    wr = '0;
  logic [N-1:0][BW-1:0]    we = '0;
  logic [DW-1:0]           rdata = '0;
  logic [N-1:0]            gnt, rvalid;
  logic [DW-1:0]           rdo, bwr;
  logic                    bclk, brst, ben;
  logic [AW-1:0]           baddr;
  logic [BW-1:0]           bwen;

  int   checks = 0, errors = 0, cyc = 0;
  int   ptr = 0, owner = 0;
  bit   locked = 0;
  rsp_t q[$];

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Lock_SI(lock), .Addr_DI(addr),
    .Wr_DI(wr), .WrEn_SI(we), .Gnt_SO(gnt), .RValid_SO(rvalid), .RData_DO(rdo),
    .Bram_Clk_CO(bclk), .Bram_Rst_RO(brst), .Bram_En_SO(ben), .Bram_Addr_SO(baddr),
    .Bram_Wr_DO(bwr), .Bram_WrEn_SO(bwen), .Bram_Rd_DI(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: grant from the round-robin rule or the lock owner; reads retire LAT cycles later.
  always @(negedge clk) begin
    int g;
    bit acc;
    logic [N-1:0] exp_rv;
    chk("bram_rst", brst, !rst_n);
    if (!rst_n) begin
      ptr = 0;
      locked = 0;
      q.delete();
      chk("m_rst_gnt", gnt, 0);
      chk("m_rst_en", ben, 0);
      chk("m_rst_wen", bwen, 0);
      chk("m_rst_rv", rvalid, 0);
      chk("m_rst_rdata", rdo, 0);
    end else begin
      g = -1;
      if (locked) g = owner;
      else for (int k = 0; k < N; k++) if (g < 0 && req[(ptr + k) % N]) g = (ptr + k) % N;
      acc = (g >= 0) && req[g];
      chk("m_gnt", gnt, (g >= 0) ? (1 << g) : 0);
      chk("m_en", ben, acc);
      if (acc) begin
        chk("m_addr", baddr, addr[g]);
        chk("m_wr", bwr, wr[g]);
        chk("m_wen", bwen, we[g]);
      end else chk("m_wen_idle", bwen, 0);
      exp_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_rv = N'(1 << q[0].idx);
        void'(q.pop_front());
      end
      chk("m_rvalid", rvalid, exp_rv);
      if (exp_rv != 0) chk("m_rdata", rdo, rdata);
      if (acc && we[g] == '0) q.push_back('{cyc + LAT, g});
      if (locked) begin
        if (!lock[owner]) locked = 0;
      end else if (acc) begin
        ptr = (g + 1) % N;
        if (lock[g]) begin
          locked = 1;
          owner = g;
        end
      end
    end
    cyc++;
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req = '1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_en", ben, 0);
    chk("rst_rv", rvalid, 0);
    chk("rst_rdata", rdo, 0);
    // single read from requester 0
    tick(); rst_n = 1'b1; req = 3'b001; addr[0] = 16'h10; we[0] = '0;
    @(negedge clk);
    chk("t1_gnt", gnt, 3'b001); chk("t1_en", ben, 1); chk("t1_addr", baddr, 16'h10);
    tick(); req = '0;
    @(negedge clk); chk("t1_rv_early", rvalid, 0);
    tick(); rdata = 32'hCAFE0000;
    @(negedge clk); chk("t1_rv", rvalid, 3'b001); chk("t1_rdata", rdo, 32'hCAFE0000);
    // partial-byte write from requester 1
    tick(); req = 3'b010; addr[1] = 16'h20; we[1] = 4'b0011; wr[1] = 32'h12345678;
    @(negedge clk);
    chk("t5_gnt", gnt, 3'b010); chk("t5_wen", bwen, 4'b0011); chk("t5_wr", bwr, 32'h12345678);
    for (int k = 0; k <= LAT; k++) begin
      tick(); req = '0;
      @(negedge clk); chk("t5_no_rv", rvalid, 0);
    end
    // two requesters held: strict alternation starting at 0
    we[0] = 4'hF; we[1] = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick(); req = 3'b011;
      @(negedge clk); chk("t2_gnt", gnt, (k % 2) ? 3'b010 : 3'b001); chk("t2_en", ben, 1);
    end
    // lock by requester 1 blocks requester 0
    tick(); req = 3'b001;
    @(negedge clk); chk("t3_pre", gnt, 3'b001);
    tick(); req = 3'b011; lock = 3'b010;
    @(negedge clk); chk("t3_gnt_a", gnt, 3'b010);
    tick(); req = 3'b001;
    @(negedge clk); chk("t3_gnt_b", gnt, 3'b010); chk("t3_en_b", ben, 0);
    tick(); req = 3'b011; lock = '0;
    @(negedge clk); chk("t3_gnt_c", gnt, 3'b010); chk("t3_en_c", ben, 1);
    tick();
    @(negedge clk); chk("t3_gnt_d", gnt, 3'b001);
    // back-to-back reads return in issue order
    tick(); req = 3'b001; we = '0; addr[0] = 16'hA; rdata = 32'h1;
    @(negedge clk);
    tick(); req = 3'b010; addr[1] = 16'hB; rdata = 32'h2;
    @(negedge clk); chk("t4_rv0", rvalid, 0);
    tick(); req = 3'b001; addr[0] = 16'hC; rdata = 32'hA0A00001;
    @(negedge clk); chk("t4_rv1", rvalid, 3'b001); chk("t4_rd1", rdo, 32'hA0A00001);
    tick(); req = '0; rdata = 32'hB0B00002;
    @(negedge clk); chk("t4_rv2", rvalid, 3'b010); chk("t4_rd2", rdo, 32'hB0B00002);
    tick(); rdata = 32'hC0C00003;
    @(negedge clk); chk("t4_rv3", rvalid, 3'b001); chk("t4_rd3", rdo, 32'hC0C00003);
    tick();
    @(negedge clk); chk("t4_rv4", rvalid, 0);
    // reset drops an in-flight read and the pointer
    tick(); req = 3'b001;
    @(negedge clk);
    tick(); req = '0; rst_n = 1'b0;
    @(negedge clk); chk("t6_rv_a", rvalid, 0);
    tick(); rst_n = 1'b1;
    @(negedge clk); chk("t6_rv_b", rvalid, 0);
    tick();
    @(negedge clk); chk("t6_rv_c", rvalid, 0);
    tick(); req = 3'b011;
    @(negedge clk); chk("t6_gnt", gnt, 3'b001);
    // reset releases a lock
    tick(); req = 3'b001; lock = 3'b001;
    @(negedge clk);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    tick(); rst_n = 1'b1; req = 3'b010; lock = '0;
    @(negedge clk); chk("t7_gnt", gnt, 3'b010);
    repeat (3000) begin
      tick();
      rst_n = ($urandom_range(0, 199) != 0);
      req = N'($urandom);
      for (int i = 0; i < N; i++) begin
        lock[i] = ($urandom_range(0, 3) == 0);
        addr[i] = AW'($urandom);
        wr[i] = $urandom;
        we[i] = $urandom_range(0, 1) ? '0 : BW'($urandom);
      end
      rdata = $urandom;
    end
    tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
